phase_cmd_receiver: RTL and testbench
=====================================

Name: phase_cmd_receiver

Overview:
Parametrised successor to the host command receiver. It consumes bytes from the proto245 RX FIFO and locates 8-byte command frames on a byte-wise sliding window, so it resynchronises after garbage bytes. It issues single or burst phase writes of configurable address and phase width toward the phase buffer. Optionally it returns a 4-byte acknowledge frame per command on the TX FIFO, and it aborts stalled bursts on a timeout.

Parameters:
TX_FIFO_LOAD_W, 8, width of txfifo_load
RX_FIFO_LOAD_W, 8, width of rxfifo_load
ADDR_W, 8, phase address width (1..16)
PHASE_W, 8, phase value width (1..16); ADDR_W+PHASE_W <= 32
ACK_EN, 1, 1 = emit ack frame per accepted command
BURST_TIMEOUT, 65535, idle cycles allowed between burst bytes before abort (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
rxfifo_data  in  8  RX byte
rxfifo_valid  in  1  rxfifo_data valid (response to rxfifo_rd, >=1 cycle later)
rxfifo_load  in  RX_FIFO_LOAD_W  unused, kept for interface compatibility
rxfifo_empty  in  1  RX FIFO empty
rxfifo_rd  out  1  one-cycle read strobe
txfifo_load  in  TX_FIFO_LOAD_W  unused
txfifo_full  in  1  TX FIFO full
txfifo_wr  out  1  TX write strobe
txfifo_data  out  8  TX byte
phase_wr_en  out  1  one-cycle phase write pulse
phase_addr  out  ADDR_W  write address, valid with phase_wr_en
phase_data  out  PHASE_W  write value, valid with phase_wr_en
debug_led  out  1  debug LED register
read_error  out  1  sticky error flag
cmd_count  out  16  accepted frames, wraps at 0xFFFF->0

Behaviour:
- Reset: all outputs 0. The 64-bit window is cleared, state = IDLE, counters = 0. An async assert mid-burst or mid-ack abandons that burst or ack and does not resume it.
- RX handshake: at most one read outstanding. rxfifo_rd pulses for 1 cycle when !rxfifo_empty and no read is outstanding. A byte is consumed on the rxfifo_valid cycle. A new rd may issue the cycle after valid.
- Frame wire order: 0xAA, code[15:8], code[7:0], data[31:24..7:0] MSB first, 0x55.
- Each consumed byte shifts into the window (the new byte goes to the LSB). Match is evaluated the cycle after a shift: window[63:56]==0xAA and window[7:0]==0x55.
- On match the window is cleared and cmd_count increments.
- States:
  - IDLE/READ: fetch bytes and shift the window.
  - PARSE: 1 cycle, dispatch on code.
    - 0x0001: phase_addr = data[ADDR_W+PHASE_W-1:PHASE_W], phase_data = data[PHASE_W-1:0], phase_wr_en pulse. Status 0x00.
    - 0x0002: N = data[15:0]. N==0 goes straight to ACK with status 0x00. Otherwise go to BURST.
    - 0x0003: clear read_error. Status 0x00.
    - 0x1ED0: debug_led = data[0]. Status 0x00.
    - Any other code: set read_error. Status 0x01.
  - BURST: N entries, each AB = ceil(ADDR_W/8) address bytes then PB = ceil(PHASE_W/8) phase bytes, MSB first, truncated to width.
    - phase_wr_en pulses the cycle after the last byte of each entry.
    - Burst bytes do not enter the frame window.
    - After N entries, go to ACK with status 0x00.
    - Idle counter: resets on each consumed byte and increments otherwise. Reaching BURST_TIMEOUT sets read_error and goes to ACK with status 0x02. Remaining entries are dropped and later bytes parse as frames.
  - ACK: if ACK_EN, write 0xA5, code[7:0], status, 0x5A.
    - One byte per cycle, and only while !txfifo_full; full stalls with txfifo_wr=0 and data held.
    - No RX reads during ACK. If ACK_EN=0, ACK is skipped.
    - Return to IDLE.
- Latency: the last frame byte valid -> phase_wr_en (code 0x0001) is 2 cycles.
- read_error is sticky; it clears only via reset or code 0x0003.

Test Plan:
- Bytes AA 00 01 00 00 2A 7F 55 (defaults) -> phase_wr_en 1 cycle, addr=0x2A, data=0x7F; TX A5 01 00 5A; cmd_count=1.
- Garbage 13 AA 55 then a valid 0x1ED0 frame with data=1 -> no false match; debug_led=1; TX A5 D0 00 5A.
- Burst N=3 with entries (05,10)(06,20)(07,30) -> three pulses with matching addr/data; a following frame still parses.
- BURST_TIMEOUT=16, N=2, only 1 entry sent -> after 16 idle cycles read_error=1, TX status 02; the next frame parses normally.
- Unknown code 0xBEEF -> read_error=1, TX A5 EF 01 5A. Then code 0x0003 -> read_error=0.
- txfifo_full held 5 cycles during ACK -> no writes, byte held; resumes in order. rst_n low mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/phase_cmd_receiver.sv
// Host command receiver: finds 8-byte frames on a sliding byte window from the RX FIFO,
// issues single/burst phase writes and optionally answers each command with a 4-byte ack.
module phase_cmd_receiver #(
   parameter int TX_FIFO_LOAD_W = 8,
   parameter int RX_FIFO_LOAD_W = 8,
   parameter int ADDR_W         = 8,
   parameter int PHASE_W        = 8,
   parameter bit ACK_EN         = 1'b1,
   parameter int BURST_TIMEOUT  = 65535
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                rxfifo_data,
   input  logic                      rxfifo_valid,
   input  logic [RX_FIFO_LOAD_W-1:0] rxfifo_load,
   input  logic                      rxfifo_empty,
   output logic                      rxfifo_rd,
   input  logic [TX_FIFO_LOAD_W-1:0] txfifo_load,
   input  logic                      txfifo_full,
   output logic                      txfifo_wr,
   output logic [7:0]                txfifo_data,
   output logic                      phase_wr_en,
   output logic [ADDR_W-1:0]         phase_addr,
   output logic [PHASE_W-1:0]        phase_data,
   output logic                      debug_led,
   output logic                      read_error,
   output logic [15:0]               cmd_count
);

   localparam int AB    = (ADDR_W + 7) / 8;
   localparam int PB    = (PHASE_W + 7) / 8;
   localparam int EB    = AB + PB;
   localparam int ENT_W = EB * 8;
   localparam int BI_W  = $clog2(EB);
   localparam int TO_W  = $clog2(BURST_TIMEOUT + 1);
   localparam logic [BI_W-1:0] BI_LAST = BI_W'(EB - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(BURST_TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_PARSE, S_BURST, S_ACK} state_t;

   state_t              r_state, w_nxt, w_after;
   logic [63:0]         r_win;
   logic                r_rd_pend, r_rxfifo_rd;
   logic [15:0]         r_code, r_arg, r_ent_left, r_cmd_count;
   logic [7:0]          r_status;
   logic [ENT_W-9:0]    r_ent;
   logic [BI_W-1:0]     r_bidx;
   logic [TO_W-1:0]     r_idle;
   logic [1:0]          r_ack_idx;
   logic                r_phase_wr_en, r_led, r_err;
   logic [ADDR_W-1:0]   r_phase_addr;
   logic [PHASE_W-1:0]  r_phase_data;

   logic                w_take, w_match, w_burst_byte, w_entry_done, w_timeout, w_rd_ok;
   logic [ENT_W-1:0]    w_ent_full;
   logic [7:0]          w_tx_byte;
   logic                w_unused;

   assign w_unused     = ^{rxfifo_load, txfifo_load};
   assign w_after      = ACK_EN ? S_ACK : S_IDLE;
   assign w_take       = rxfifo_valid & r_rd_pend;
   assign w_match      = (r_state == S_IDLE) && (r_win[63:56] == 8'hAA) && (r_win[7:0] == 8'h55);
   assign w_burst_byte = (r_state == S_BURST) && w_take;
   assign w_entry_done = w_burst_byte && (r_bidx == BI_LAST);
   assign w_timeout    = (r_state == S_BURST) && !w_take && (r_idle == TO_LAST);
   assign w_ent_full   = {r_ent, rxfifo_data};

   // Reads only issue when the FSM stays in a fetching state, so no byte is ever in flight at a match or on entering ACK.
   assign w_rd_ok = !rxfifo_empty && !r_rd_pend && (w_nxt == r_state) &&
                    ((r_state == S_IDLE) || (r_state == S_BURST));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_match) w_nxt = S_PARSE;
         S_PARSE: begin
            if ((r_code == 16'h0002) && (r_arg != 16'd0)) w_nxt = S_BURST;
            else                                          w_nxt = w_after;
         end
         S_BURST: if ((w_entry_done && (r_ent_left == 16'd1)) || w_timeout) w_nxt = w_after;
         S_ACK:   if (!txfifo_full && (r_ack_idx == 2'd3)) w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win         <= '0;
         r_rd_pend     <= 1'b0;
         r_rxfifo_rd   <= 1'b0;
         r_code        <= '0;
         r_arg         <= '0;
         r_ent_left    <= '0;
         r_cmd_count   <= '0;
         r_status      <= '0;
         r_ent         <= '0;
         r_bidx        <= '0;
         r_idle        <= '0;
         r_ack_idx     <= '0;
         r_phase_wr_en <= 1'b0;
         r_phase_addr  <= '0;
         r_phase_data  <= '0;
         r_led         <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_phase_wr_en <= 1'b0;
         r_rxfifo_rd   <= w_rd_ok;
         if (w_rd_ok)     r_rd_pend <= 1'b1;
         else if (w_take) r_rd_pend <= 1'b0;

         if (w_take && (r_state != S_BURST)) r_win <= {r_win[55:0], rxfifo_data};
         else if (w_match)                    r_win <= '0;

         // Single writes launch straight from the matched window to keep valid->pulse at two cycles.
         if (w_match) begin
            r_code        <= r_win[55:40];
            r_arg         <= r_win[23:8];
            r_cmd_count   <= r_cmd_count + 16'd1;
            r_status      <= 8'h00;
            r_phase_wr_en <= (r_win[55:40] == 16'h0001);
            r_phase_addr  <= r_win[8+PHASE_W +: ADDR_W];
            r_phase_data  <= r_win[8 +: PHASE_W];
         end

         if (r_state == S_PARSE) begin
            case (r_code)
               16'h0001: ;
               16'h0002: begin
                  r_ent_left <= r_arg;
                  r_bidx     <= '0;
                  r_idle     <= '0;
                  r_ent      <= '0;
               end
               16'h0003: r_err <= 1'b0;
               16'h1ED0: r_led <= r_arg[0];
               default: begin
                  r_err    <= 1'b1;
                  r_status <= 8'h01;
               end
            endcase
         end

         if (r_state == S_BURST) begin
            if (w_take) begin
               r_idle <= '0;
               if (w_entry_done) begin
                  r_phase_wr_en <= 1'b1;
                  r_phase_addr  <= w_ent_full[PB*8 +: ADDR_W];
                  r_phase_data  <= w_ent_full[PHASE_W-1:0];
                  r_ent_left    <= r_ent_left - 16'd1;
                  r_bidx        <= '0;
               end else begin
                  r_ent  <= w_ent_full[ENT_W-9:0];
                  r_bidx <= r_bidx + 1'b1;
               end
            end else begin
               r_idle <= r_idle + 1'b1;
               if (w_timeout) begin
                  r_err    <= 1'b1;
                  r_status <= 8'h02;
               end
            end
         end

         if (r_state == S_ACK) begin
            if (!txfifo_full) r_ack_idx <= r_ack_idx + 2'd1;
         end else begin
            r_ack_idx <= '0;
         end
      end
   end

   always_comb begin
      w_tx_byte = 8'h00;
      if (r_state == S_ACK) begin
         case (r_ack_idx)
            2'd0:    w_tx_byte = 8'hA5;
            2'd1:    w_tx_byte = r_code[7:0];
            2'd2:    w_tx_byte = r_status;
            default: w_tx_byte = 8'h5A;
         endcase
      end
   end

   assign rxfifo_rd   = r_rxfifo_rd;
   assign txfifo_wr   = (r_state == S_ACK) && !txfifo_full;
   assign txfifo_data = w_tx_byte;
   assign phase_wr_en = r_phase_wr_en;
   assign phase_addr  = r_phase_addr;
   assign phase_data  = r_phase_data;
   assign debug_led   = r_led;
   assign read_error  = r_err;
   assign cmd_count   = r_cmd_count;

endmodule

// File: tb/tb_phase_cmd_receiver.sv
// Bench for phase_cmd_receiver: byte-level command model with expected write/ack queues,
// an RX FIFO responder, and a per-cycle monitor comparing DUT outputs to the model.
module tb_phase_cmd_receiver;

   localparam int AW = 8;
   localparam int PW = 8;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rxfifo_data;
   logic        rxfifo_valid;
   logic [7:0]  rxfifo_load = 8'h00;
   logic        rxfifo_empty;
   logic        rxfifo_rd;
   logic [7:0]  txfifo_load = 8'h00;
   logic        txfifo_full;
   logic        txfifo_wr;
   logic [7:0]  txfifo_data;
   logic        phase_wr_en;
   logic [AW-1:0] phase_addr;
   logic [PW-1:0] phase_data;
   logic        debug_led;
   logic        read_error;
   logic [15:0] cmd_count;

   phase_cmd_receiver #(.ADDR_W(AW), .PHASE_W(PW), .ACK_EN(1'b1), .BURST_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .rxfifo_data(rxfifo_data), .rxfifo_valid(rxfifo_valid), .rxfifo_load(rxfifo_load),
      .rxfifo_empty(rxfifo_empty), .rxfifo_rd(rxfifo_rd),
      .txfifo_load(txfifo_load), .txfifo_full(txfifo_full), .txfifo_wr(txfifo_wr),
      .txfifo_data(txfifo_data), .phase_wr_en(phase_wr_en), .phase_addr(phase_addr),
      .phase_data(phase_data), .debug_led(debug_led), .read_error(read_error),
      .cmd_count(cmd_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_valid_cyc = 0;
   int ph_cyc = 0;
   int n_ph = 0;
   logic [AW-1:0] last_addr;
   logic [PW-1:0] last_data;

   logic [7:0]  rxq[$];
   logic [15:0] exp_ph[$];
   logic [7:0]  exp_tx[$];
   logic [7:0]  tx_log[$];
   logic [15:0] exp_cmd = 16'd0;
   logic        exp_err = 1'b0;
   logic        exp_led = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, {rxfifo_rd, txfifo_wr, txfifo_data, phase_wr_en, phase_addr, phase_data,
                   debug_led, read_error, cmd_count}, 64'd0);
   endtask

   function automatic logic [31:0] tx32();
      if (tx_log.size() < 4) return 32'hFFFF_FFFF;
      return {tx_log[0], tx_log[1], tx_log[2], tx_log[3]};
   endfunction

   // RX FIFO responder: data returns the cycle after a sampled read strobe.
   initial begin
      logic r;
      rxfifo_valid = 1'b0;
      rxfifo_data  = 8'h00;
      rxfifo_empty = 1'b1;
      forever begin
         @(negedge clk);
         r = rxfifo_rd;
         @(posedge clk);
         #1;
         rxfifo_valid = 1'b0;
         if (r && rxq.size() > 0) begin
            rxfifo_data    = rxq.pop_front();
            rxfifo_valid   = 1'b1;
            last_valid_cyc = cyc;
         end
         rxfifo_empty = (rxq.size() == 0);
      end
   end

   // Monitor: every phase pulse and every TX write is checked against the model queues.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (phase_wr_en) begin
               n_ph++;
               ph_cyc    = cyc;
               last_addr = phase_addr;
               last_data = phase_data;
               if (exp_ph.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL phase_unexpected actual=%0h_%0h required=none", phase_addr, phase_data);
               end else begin
                  check("phase_write", {phase_addr, phase_data}, exp_ph.pop_front());
               end
            end
            if (txfifo_full) check("tx_wr_while_full", txfifo_wr, 1'b0);
            if (txfifo_wr) begin
               tx_log.push_back(txfifo_data);
               if (exp_tx.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL tx_unexpected actual=%0h required=none", txfifo_data);
               end else begin
                  check("tx_byte", txfifo_data, exp_tx.pop_front());
               end
            end
         end
      end
   end

   task automatic push_ack(input logic [15:0] code, input logic [7:0] status);
      exp_tx.push_back(8'hA5);
      exp_tx.push_back(code[7:0]);
      exp_tx.push_back(status);
      exp_tx.push_back(8'h5A);
   endtask

   task automatic push_frame_bytes(input logic [15:0] code, input logic [31:0] data);
      rxq.push_back(8'hAA);
      rxq.push_back(code[15:8]);
      rxq.push_back(code[7:0]);
      for (int i = 3; i >= 0; i--) rxq.push_back(data[i*8 +: 8]);
      rxq.push_back(8'h55);
   endtask

   task automatic push_frame(input logic [15:0] code, input logic [31:0] data);
      logic [7:0] st;
      st = 8'h00;
      push_frame_bytes(code, data);
      exp_cmd = exp_cmd + 16'd1;
      case (code)
         16'h0001: exp_ph.push_back({data[AW+PW-1:PW], data[PW-1:0]});
         16'h0003: exp_err = 1'b0;
         16'h1ED0: exp_led = data[0];
         default: begin exp_err = 1'b1; st = 8'h01; end
      endcase
      push_ack(code, st);
   endtask

   task automatic push_burst(input int n, input int sent, input logic [2:0][15:0] ents);
      push_frame_bytes(16'h0002, n);
      exp_cmd = exp_cmd + 16'd1;
      for (int i = 0; i < sent; i++) begin
         rxq.push_back(ents[i][15:8]);
         rxq.push_back(ents[i][7:0]);
         exp_ph.push_back(ents[i]);
      end
      if (sent >= n) push_ack(16'h0002, 8'h00);
      else begin exp_err = 1'b1; push_ack(16'h0002, 8'h02); end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      while ((rxq.size() != 0 || exp_ph.size() != 0 || exp_tx.size() != 0) && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (k >= budget) begin
         n_chk++; n_fail++;
         $display("FAIL %s_timeout actual=pending(rx=%0d ph=%0d tx=%0d) required=drained",
                  name, rxq.size(), exp_ph.size(), exp_tx.size());
      end
      repeat (4) @(negedge clk);
      check({name, "_cmd_count"}, cmd_count, exp_cmd);
      check({name, "_read_error"}, read_error, exp_err);
      check({name, "_debug_led"}, debug_led, exp_led);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int ph0;
      rst_n       = 1'b0;
      txfifo_full = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_outputs");
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("idle_outputs");

      // single write with default widths
      tx_log.delete();
      push_frame(16'h0001, 32'h0000_2A7F);
      wait_idle("single", 300);
      check("single_latency", ph_cyc - last_valid_cyc, 2);
      check("single_addr", last_addr, 8'h2A);
      check("single_data", last_data, 8'h7F);
      check("single_ack", tx32(), 32'hA501_005A);
      check("single_count", cmd_count, 16'd1);

      // garbage before a debug-led frame must not false-match
      tx_log.delete();
      rxq.push_back(8'h13); rxq.push_back(8'hAA); rxq.push_back(8'h55);
      push_frame(16'h1ED0, 32'h0000_0001);
      wait_idle("garbage_led", 400);
      check("led_ack", tx32(), 32'hA5D0_005A);
      check("led_on", debug_led, 1'b1);

      // full burst followed by a normal frame
      ph0 = n_ph;
      push_burst(3, 3, {16'h0730, 16'h0620, 16'h0510});
      push_frame(16'h0001, 32'h0000_1122);
      wait_idle("burst", 600);
      check("burst_pulses", n_ph - ph0, 4);

      // stalled burst times out, next frame still parses
      tx_log.delete();
      push_burst(2, 1, {16'h0000, 16'h0000, 16'h0940});
      wait_idle("burst_timeout", 400);
      check("timeout_ack", tx32(), 32'hA502_025A);
      check("timeout_err", read_error, 1'b1);
      push_frame(16'h0001, 32'h0000_3344);
      wait_idle("after_timeout", 300);

      // unknown code, then error clear
      tx_log.delete();
      push_frame(16'hBEEF, 32'h0000_0000);
      wait_idle("unknown", 300);
      check("unknown_ack", tx32(), 32'hA5EF_015A);
      push_frame(16'h0003, 32'h0000_0000);
      wait_idle("clear_err", 300);
      check("err_cleared", read_error, 1'b0);

      // TX full stall during ack
      tx_log.delete();
      push_frame(16'h1ED0, 32'h0000_0000);
      k = 0;
      while (!txfifo_wr && k < 300) begin @(negedge clk); k++; end
      check("stall_reached_ack", txfifo_wr, 1'b1);
      @(posedge clk); #1 txfifo_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_no_wr", txfifo_wr, 1'b0);
         if (exp_tx.size() > 0) check("stall_data_held", txfifo_data, exp_tx[0]);
      end
      @(posedge clk); #1 txfifo_full = 1'b0;
      wait_idle("stall", 300);
      check("stall_ack_order", tx32(), 32'hA5D0_005A);

      // reset in the middle of a burst
      push_burst(3, 1, {16'h0000, 16'h0000, 16'h0A55});
      k = 0;
      while (exp_ph.size() != 0 && k < 300) begin @(negedge clk); k++; end
      check("midburst_entry_seen", exp_ph.size(), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_outputs_zero("midburst_reset_outputs");
      exp_tx.delete(); exp_ph.delete(); rxq.delete();
      exp_cmd = 16'd0; exp_err = 1'b0; exp_led = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_count", cmd_count, 16'd0);
      push_frame(16'h0001, 32'h0000_5566);
      wait_idle("post_reset", 300);
      check("post_reset_addr", last_addr, 8'h55);
      check("post_reset_data", last_data, 8'h66);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
